mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 32-bit 4x1 multiplexer datapath among four requesters.
- Drives the mux select lines from a registered one-hot grant.
- Registers the selected word onto an output bus with a valid flag.
- Enforces a bounded hold time so no requester monopolises the mux while others wait.
- Sits between the four data sources and the single downstream consumer of the muxed bus.

---
 rtl/mux4_rr_arbiter_pkg.sv | 15 +
 rtl/mux4_rr_arbiter_mux_4x1.sv | 26 ++
 rtl/mux4_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: state encoding,
// default parameters and the source index type.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_MAX_HOLD = 8;

    typedef logic [1:0] src_idx_t;

endpackage

// File: rtl/mux4_rr_arbiter_mux_4x1.sv
// Purely combinational 4:1 word multiplexer driven by a 2-bit select.
module mux_4x1
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  src_idx_t         sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = i0;
        case (sel)
            2'd0: y = i0;
            2'd1: y = i1;
            2'd2: y = i2;
            2'd3: y = i3;
            default: y = i0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux: registered one-hot grant and
// select, bounded hold time, and a registered output word with valid flag.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic [3:0]       gnt,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] Y,
    output logic             valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_reg, state_next;
    src_idx_t         ptr_reg, ptr_next;
    logic [7:0]       hcnt_reg, hcnt_next;
    logic [3:0]       gnt_reg, gnt_next;
    src_idx_t         s_reg, s_next;
    logic [WIDTH-1:0] y_reg;
    logic             valid_reg;

    logic [WIDTH-1:0] y_mux;
    logic [3:0]       pick_mask;
    logic [3:0]       others;
    src_idx_t         pick_idx;
    logic             pick_found;
    src_idx_t         cand_idx [4];

    mux_4x1 #(.WIDTH(WIDTH)) u_mux (
        .sel (s_reg),
        .i0  (I0),
        .i1  (I1),
        .i2  (I2),
        .i3  (I3),
        .y   (y_mux)
    );

    // Scan order starts just after the last owner; the owner itself comes last.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand_idx[gi] = ptr_reg + 2'(gi + 1);
    end

    // The current owner is always ptr_reg, so masking it out excludes it from handover.
    assign others    = req & ~(4'b0001 << ptr_reg);
    assign pick_mask = (state_reg == ST_IDLE) ? req : others;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_reg;
        for (int n = 3; n >= 0; n--) begin
            if (pick_mask[cand_idx[n]]) begin
                pick_idx   = cand_idx[n];
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        hcnt_next  = hcnt_reg;
        gnt_next   = gnt_reg;
        s_next     = s_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_GRANT;
                    gnt_next   = 4'b0001 << pick_idx;
                    s_next     = pick_idx;
                    ptr_next   = pick_idx;
                    hcnt_next  = 8'd0;
                end
            end
            ST_GRANT: begin
                // Release wins over hold expiry when both happen in one cycle.
                if (req[ptr_reg] && !(hcnt_reg == HOLD_LAST && pick_found)) begin
                    if (hcnt_reg != HOLD_LAST) begin
                        hcnt_next = hcnt_reg + 8'd1;
                    end
                end else if (pick_found) begin
                    gnt_next  = 4'b0001 << pick_idx;
                    s_next    = pick_idx;
                    ptr_next  = pick_idx;
                    hcnt_next = 8'd0;
                end else begin
                    state_next = ST_IDLE;
                    gnt_next   = 4'b0000;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 2'd3;
            hcnt_reg  <= 8'd0;
            gnt_reg   <= 4'b0000;
            s_reg     <= 2'd0;
            y_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            hcnt_reg  <= hcnt_next;
            gnt_reg   <= gnt_next;
            s_reg     <= s_next;
            if (state_reg == ST_GRANT) begin
                y_reg     <= y_mux;
                valid_reg <= 1'b1;
            end else begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign gnt   = gnt_reg;
    assign S     = s_reg;
    assign Y     = y_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with the default hold
// limit and one with a hold limit of 1, sharing all inputs.
module tb_mux4_rr_arbiter;
    import mux4_rr_arbiter_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;

    logic [3:0]   gnt8, gnt1;
    logic [1:0]   s8, s1;
    logic [W-1:0] y8, y1;
    logic         valid8, valid1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(8)) dut8 (
        .clk(clk), .reset(reset), .req(req),
        .I0(i0), .I1(i1), .I2(i2), .I3(i3),
        .gnt(gnt8), .S(s8), .Y(y8), .valid(valid8)
    );

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .req(req),
        .I0(i0), .I1(i1), .I2(i2), .I3(i3),
        .gnt(gnt1), .S(s1), .Y(y1), .valid(valid1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and first grant
        reset = 1'b1;
        tick();
        tick();
        check("rst_gnt", 32'(gnt8), 32'h0);
        check("rst_s", 32'(s8), 32'h0);
        check("rst_y", y8, 32'h0);
        check("rst_valid", 32'(valid8), 32'h0);
        check("rst_gnt_h1", 32'(gnt1), 32'h0);
        $display("reset: gnt=%b S=%b Y=%h valid=%b", gnt8, s8, y8, valid8);
        reset = 1'b0;
        i0 = 32'h0000AAAA; i1 = 32'hAAAA0000; i2 = 32'h0000FFFF; i3 = 32'hFFFF0000;
        req = 4'b0100;
        tick();
        check("first_gnt", 32'(gnt8), 32'h4);
        check("first_s", 32'(s8), 32'h2);
        check("first_valid_lat", 32'(valid8), 32'h0);
        $display("first grant: gnt=%b S=%b valid=%b", gnt8, s8, valid8);
        tick();
        check("first_y", y8, 32'h0000FFFF);
        check("first_valid", 32'(valid8), 32'h1);
        $display("first data: Y=%h valid=%b", y8, valid8);

        // Round-robin rotation with MAX_HOLD=1
        do_reset();
        req = 4'b1111;
        begin
            logic [3:0]  exp_g [5];
            logic [31:0] exp_y [5];
            exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            exp_y = '{32'h0, 32'h0000AAAA, 32'hAAAA0000, 32'h0000FFFF, 32'hFFFF0000};
            for (int n = 0; n < 5; n++) begin
                tick();
                check($sformatf("rr_gnt[%0d]", n), 32'(gnt1), 32'(exp_g[n]));
                if (n > 0) check($sformatf("rr_y[%0d]", n), y1, exp_y[n]);
                $display("rr step %0d: gnt=%b Y=%h", n, gnt1, y1);
            end
        end

        // Hold expiry with MAX_HOLD=8
        do_reset();
        req = 4'b0011;
        for (int n = 0; n < 17; n++) begin
            tick();
            check($sformatf("hold_gnt[%0d]", n), 32'(gnt8),
                  (n < 8) ? 32'h1 : (n < 16) ? 32'h2 : 32'h1);
            $display("hold cycle %0d: gnt=%b", n, gnt8);
        end

        // Release handover without a bubble
        do_reset();
        req = 4'b0001;
        tick();
        check("ho_gnt0", 32'(gnt8), 32'h1);
        req = 4'b1001;
        tick();
        check("ho_keep", 32'(gnt8), 32'h1);
        check("ho_y0", y8, 32'h0000AAAA);
        req = 4'b1000;
        tick();
        check("ho_gnt", 32'(gnt8), 32'h8);
        check("ho_s", 32'(s8), 32'h3);
        check("ho_valid", 32'(valid8), 32'h1);
        check("ho_y_old", y8, 32'h0000AAAA);
        tick();
        check("ho_valid2", 32'(valid8), 32'h1);
        check("ho_y_new", y8, 32'hFFFF0000);
        $display("handover: gnt=%b S=%b Y=%h valid=%b", gnt8, s8, y8, valid8);

        // Lone requester, then idle
        do_reset();
        req = 4'b0010;
        for (int n = 0; n < 20; n++) begin
            tick();
            check($sformatf("lone_gnt[%0d]", n), 32'(gnt8), 32'h2);
            if (n > 0) check($sformatf("lone_valid[%0d]", n), 32'(valid8), 32'h1);
        end
        $display("lone: gnt=%b Y=%h valid=%b", gnt8, y8, valid8);
        req = 4'b0000;
        tick();
        check("idle_gnt", 32'(gnt8), 32'h0);
        check("idle_s_hold", 32'(s8), 32'h1);
        check("idle_valid_lat", 32'(valid8), 32'h1);
        tick();
        check("idle_valid", 32'(valid8), 32'h0);
        check("idle_y_hold", y8, 32'hAAAA0000);
        $display("idle: gnt=%b S=%b Y=%h valid=%b", gnt8, s8, y8, valid8);

        // One-cycle request pulse sampled in IDLE
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check("pulse_gnt", 32'(gnt8), 32'h8);
        tick();
        check("pulse_drop", 32'(gnt8), 32'h0);
        check("pulse_y", y8, 32'hFFFF0000);
        $display("pulse: gnt=%b Y=%h valid=%b", gnt8, y8, valid8);

        // Reset mid-grant, then pointer restarts at source 0
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b1111;
        tick();
        check("mid_gnt", 32'(gnt8), 32'h4);
        reset = 1'b1;
        tick();
        check("mid_rst_gnt", 32'(gnt8), 32'h0);
        check("mid_rst_y", y8, 32'h0);
        check("mid_rst_valid", 32'(valid8), 32'h0);
        reset = 1'b0;
        req = 4'b0000;
        tick();
        req = 4'b1111;
        tick();
        check("post_rst_gnt", 32'(gnt8), 32'h1);
        check("post_rst_s", 32'(s8), 32'h0);
        $display("post reset: gnt=%b S=%b", gnt8, s8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
